// File: rtl/aes_enc_sched_if.sv
// Handshake bundle for aes_enc_sched: key stream, two block requesters,
// result port and the my_aes_encipher core connection.
//
// Ports (slave = scheduler side, master = environment side):
//   key_reload, rk_valid/rk_ready/rk_data  key load control and stream
//   reqN_valid/reqN_ready/reqN_block       requester N block input
//   res_valid/res_ready/res_data/res_id    ciphertext result
//   keys_loaded, err_timeout               status
//   core_*                                 my_aes_encipher core signals
interface aes_enc_sched_if;
    logic         key_reload;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_ready;
    logic         req0_valid;
    logic [127:0] req0_block;
    logic         req0_ready;
    logic         req1_valid;
    logic [127:0] req1_block;
    logic         req1_ready;
    logic         res_valid;
    logic [127:0] res_data;
    logic         res_id;
    logic         res_ready;
    logic         keys_loaded;
    logic         err_timeout;
    logic         core_next;
    logic [127:0] core_block;
    logic [3:0]   core_init_round;
    logic [127:0] core_init_roundkey;
    logic         core_init_roundkey_valid;
    logic [127:0] core_encblock;
    logic         core_result_valid;
    logic         core_is_idle;

    modport slave (
        input  key_reload, rk_valid, rk_data,
        input  req0_valid, req0_block,
        input  req1_valid, req1_block,
        input  res_ready,
        input  core_encblock, core_result_valid,
        input  core_is_idle,
        output rk_ready, req0_ready, req1_ready,
        output res_valid, res_data, res_id,
        output keys_loaded, err_timeout,
        output core_next, core_block,
        output core_init_round, core_init_roundkey,
        output core_init_roundkey_valid
    );

    modport master (
        output key_reload, rk_valid, rk_data,
        output req0_valid, req0_block,
        output req1_valid, req1_block,
        output res_ready,
        output core_encblock, core_result_valid,
        output core_is_idle,
        input  rk_ready, req0_ready, req1_ready,
        input  res_valid, res_data, res_id,
        input  keys_loaded, err_timeout,
        input  core_next, core_block,
        input  core_init_round, core_init_roundkey,
        input  core_init_roundkey_valid
    );
endinterface

// File: rtl/aes_enc_sched.sv
// Key-load controller and round-robin block scheduler for one
// my_aes_encipher core, with a held valid/ready result port.
//
// Ports:
//   clk   clock, posedge
//   rst   asynchronous active-low reset
//   bus   aes_enc_sched_if.slave (key stream, requesters, result, core)
// Optional: define AES_ENC_SCHED_WDOG_EN for a BUSY watchdog that sets
// the sticky err_timeout flag and drops the stalled block.
module aes_enc_sched #(
    parameter int NUM_RK = 11
`ifdef AES_ENC_SCHED_WDOG_EN
    ,
    parameter int WDOG_LIMIT = 32
`endif
) (
    input  logic           clk,
    input  logic           rst,
    aes_enc_sched_if.slave bus
);
    typedef enum logic [1:0] {
        S_KEYLOAD,
        S_IDLE,
        S_BUSY,
        S_HOLD
    } state_t;

    localparam logic [3:0] RK_LAST = 4'(NUM_RK - 1);

    state_t       r_state;
    logic [3:0]   r_rk_cnt;
    logic         r_keys_loaded;
    logic         r_last_grant;
    logic         r_cur_id;
    logic         r_res_valid;
    logic [127:0] r_res_data;
    logic         r_res_id;

    logic         w_rk_fire;
    logic         w_idle_free;
    logic         w_g0;
    logic         w_g1;
    logic         w_grant;

`ifdef AES_ENC_SCHED_WDOG_EN
    localparam logic [5:0] WDOG_LAST = 6'(WDOG_LIMIT - 1);
    logic [5:0]   r_wdog;
    logic         r_err_timeout;
    assign bus.err_timeout = r_err_timeout;
`else
    assign bus.err_timeout = 1'b0;
`endif

    // Gated by rst so that every ready output reads 0 while in reset.
    assign bus.rk_ready = rst & (r_state == S_KEYLOAD);
    assign w_rk_fire    = bus.rk_ready & bus.rk_valid;

    // Reload wins over requests; the core must be idle to take a block.
    assign w_idle_free = (r_state == S_IDLE) & ~bus.key_reload
                       & bus.core_is_idle;
    // Round robin: on contention grant the side that did not win last.
    assign w_g0 = w_idle_free & bus.req0_valid
                & (~bus.req1_valid | r_last_grant);
    assign w_g1 = w_idle_free & bus.req1_valid
                & (~bus.req0_valid | ~r_last_grant);
    assign w_grant = w_g0 | w_g1;

    assign bus.req0_ready = w_g0;
    assign bus.req1_ready = w_g1;
    assign bus.core_next  = w_grant;
    assign bus.core_block = w_g1 ? bus.req1_block :
                            w_g0 ? bus.req0_block : '0;

    assign bus.core_init_roundkey_valid = w_rk_fire;
    assign bus.core_init_round          = r_rk_cnt;
    assign bus.core_init_roundkey       = bus.rk_data;

    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_id      = r_res_id;
    assign bus.keys_loaded = r_keys_loaded;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_KEYLOAD;
            r_rk_cnt      <= '0;
            r_keys_loaded <= 1'b0;
            r_last_grant  <= 1'b1;
            r_cur_id      <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_id      <= 1'b0;
`ifdef AES_ENC_SCHED_WDOG_EN
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_KEYLOAD: begin
                    if (w_rk_fire) begin
                        if (r_rk_cnt == RK_LAST) begin
                            r_rk_cnt      <= '0;
                            r_keys_loaded <= 1'b1;
                            r_state       <= S_IDLE;
                        end else begin
                            r_rk_cnt <= r_rk_cnt + 4'd1;
                        end
                    end
                end
                S_IDLE: begin
                    if (bus.key_reload) begin
                        r_rk_cnt      <= '0;
                        r_keys_loaded <= 1'b0;
                        r_state       <= S_KEYLOAD;
                    end else if (w_grant) begin
                        r_last_grant <= w_g1;
                        r_cur_id     <= w_g1;
                        r_state      <= S_BUSY;
`ifdef AES_ENC_SCHED_WDOG_EN
                        r_wdog       <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    if (bus.core_result_valid) begin
                        r_res_data  <= bus.core_encblock;
                        r_res_id    <= r_cur_id;
                        r_res_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
`ifdef AES_ENC_SCHED_WDOG_EN
                    else if (r_wdog == WDOG_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 6'd1;
                    end
`endif
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_KEYLOAD;
            endcase
        end
    end
endmodule

// File: doc/aes_enc_sched.md
Name: aes_enc_sched

Overview:
- Controller/scheduler in front of one my_aes_encipher core.
- After reset, or on request, it loads the 11 AES-128 round keys into the core from a valid/ready key stream.
- It then shares the core between two block requesters using round-robin arbitration, and returns each ciphertext with its requester ID through a held valid/ready result port.

Parameters:
NUM_RK, 11, number of round keys loaded per key load (rounds 0..10)
WDOG_LIMIT, 32, BUSY-cycle limit for the optional watchdog

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous active-low reset (reset when rst=0)
key_reload  in  1  one-cycle pulse; requests a new key load; honoured only in IDLE
rk_valid  in  1  round-key stream valid
rk_data  in  128  round key; keys arrive in order, round 0 first
rk_ready  out  1  high only in KEYLOAD
req0_valid  in  1  requester 0 has a block
req0_block  in  128  requester 0 plaintext
req0_ready  out  1  one-cycle accept strobe for requester 0
req1_valid  in  1  requester 1 has a block
req1_block  in  128  requester 1 plaintext
req1_ready  out  1  one-cycle accept strobe for requester 1
res_valid  out  1  ciphertext available; held until res_ready
res_data  out  128  ciphertext
res_id  out  1  requester that owns res_data
res_ready  in  1  result consumer accepts
keys_loaded  out  1  high once all NUM_RK keys have been written
err_timeout  out  1  sticky watchdog flag (see Optional Feature)
core_next  out  1  to core next
core_block  out  128  to core block
core_init_round  out  4  to core init_round
core_init_roundkey  out  128  to core init_roundkey
core_init_roundkey_valid  out  1  to core init_roundkey_valid
core_encblock  in  128  from core encblock
core_result_valid  in  1  from core result_valid (one-cycle pulse)
core_is_idle  in  1  from core is_idle, bit 0

Behaviour:
- Reset values:
  - state=KEYLOAD; rk_cnt=0; keys_loaded=0; last_grant=1; err_timeout=0.
  - All ready/valid outputs and core_next = 0; res_data=0, res_id=0.
- Reset mid-operation is legal. All state is discarded, any in-flight result is lost, and a full key load is required again.
- KEYLOAD:
  - rk_ready=1.
  - On each rk_valid&rk_ready cycle: core_init_roundkey_valid=1, core_init_round=rk_cnt, core_init_roundkey=rk_data (all combinational from inputs); rk_cnt increments.
  - When a word is accepted with rk_cnt==NUM_RK-1: rk_cnt->0, keys_loaded->1, next state IDLE.
  - keys_loaded is cleared on entry to KEYLOAD.
- IDLE:
  - If key_reload=1, go to KEYLOAD. Reload has priority over requests in the same cycle.
  - Otherwise, if core_is_idle=1 and any reqX_valid, grant one requester:
    - If only one requester is valid, grant it.
    - If both are valid, grant the one that is not last_grant.
  - On grant: reqX_ready=1, core_next=1, core_block=reqX_block (same cycle, combinational); last_grant<=X; cur_id<=X; next state BUSY.
- BUSY:
  - reqX_ready=0 and core_next=0.
  - On core_result_valid=1: res_data<=core_encblock, res_id<=cur_id, res_valid<=1; next state HOLD.
- HOLD:
  - res_valid=1; res_data and res_id held stable.
  - On res_ready=1: res_valid<=0; next state IDLE.
  - A new block is accepted no earlier than the cycle after res_ready.
- key_reload outside IDLE is ignored (not queued).
- Latency: acceptance cycle T, core result_valid in T+12, res_valid high from T+13.
- Throughput: at most one block per 14 cycles with res_ready tied high.
- rk_valid outside KEYLOAD is ignored (rk_ready=0).

Optional Feature:
- Macro AES_ENC_SCHED_WDOG_EN.
- Defined:
  - A 6-bit counter clears on BUSY entry and increments each BUSY cycle.
  - If it reaches WDOG_LIMIT without core_result_valid: err_timeout<=1 (sticky until reset), the block is dropped (no res_valid), next state IDLE.
- Not defined: no counter; err_timeout is constant 0; BUSY waits indefinitely.

Test Plan:
- Key load: reset, stream the FIPS-197 AES-128 expansion of key 000102030405060708090a0b0c0d0e0f (11 words) with rk_valid held high -> 11 core_init_roundkey_valid pulses, rounds 0..10 in order; keys_loaded=1 in the cycle after the 11th word.
- Single block: req0 sends 00112233445566778899aabbccddeeff -> req0_ready pulse at T; res_valid at T+13 with res_data=69c4e0d86a7b0430d8cdb78070b4c55a and res_id=0.
- Arbitration: req0 and req1 both valid continuously with res_ready=1 -> grants alternate 0,1,0,1 and res_id sequence 0,1,0,1.
- Backpressure: res_ready=0 for 20 cycles after res_valid -> res_data stable, no new req ready during that time; accept in the cycle after res_ready=1.
- Reload and reset: key_reload in IDLE with req0_valid=1 -> KEYLOAD entered, no grant, keys_loaded=0. Separately, drive rst=0 during BUSY -> all outputs return to reset values immediately.
- With AES_ENC_SCHED_WDOG_EN and core_result_valid forced 0 -> err_timeout=1 after 32 BUSY cycles, back to IDLE, no res_valid.
